// File: rtl/goose_pkg.sv
`default_nettype none
// ============================================================================
// Module   : goose_pkg
// Purpose  : Shared constants and types for the goose sprite animator.
//            H_ACTIVE / V_ACTIVE : visible raster size in pixels.
//            rgb6_t              : {R[1:0],G[1:0],B[1:0]} colour word.
//            motion_state_t      : horizontal motion FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package goose_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [5:0] rgb6_t;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2
  } motion_state_t;

endpackage
`default_nettype wire

// File: rtl/goose_palette.sv
`default_nettype none
// ============================================================================
// Module   : goose_palette
// Purpose  : Combinational palette lookup with a 2x2 ordered dither.
//            Each colour index has a base colour and a shade; the shade is
//            used on the subpixel phase 2'b11 so large flat areas get a
//            little texture at 6-bit colour depth.
// Ports    : idx      in  IDX_W  palette index (0 = transparent, maps to 0)
//            subpixel in  2      pix_x[1:0] ^ pix_y[1:0] of the pixel
//            rgb      out 6      {R[1:0],G[1:0],B[1:0]}
// Revision : 1.0 - initial release
// ============================================================================
module goose_palette
  import goose_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       subpixel,
  output logic [5:0]       rgb
);

  logic [2:0] w_sel;
  logic       w_use_shade;
  rgb6_t      w_base;
  rgb6_t      w_shade;

  // Only eight colours exist; wider indices fold onto them.
  assign w_sel       = 3'(idx);
  assign w_use_shade = (subpixel == 2'b11);

  always_comb begin
    w_base  = 6'b000000;
    w_shade = 6'b000000;
    case (w_sel)
      3'd1: begin w_base = 6'b111111; w_shade = 6'b101010; end // body white
      3'd2: begin w_base = 6'b101010; w_shade = 6'b010101; end // wing grey
      3'd3: begin w_base = 6'b111000; w_shade = 6'b110100; end // beak orange
      3'd4: begin w_base = 6'b000000; w_shade = 6'b000000; end // eye black
      3'd5: begin w_base = 6'b110100; w_shade = 6'b100100; end // feet
      3'd6: begin w_base = 6'b010101; w_shade = 6'b000001; end // shadow
      3'd7: begin w_base = 6'b111100; w_shade = 6'b111000; end // highlight
      default: begin w_base = 6'b000000; w_shade = 6'b000000; end
    endcase
  end

  assign rgb = w_use_shade ? w_shade : w_base;

endmodule
`default_nettype wire

// File: rtl/goose_sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : goose_sprite_animator
// Purpose  : Animated, horizontally bouncing sprite renderer placed between
//            hvsync_generator and the video output. Steps through
//            NUM_FRAMES frames of an external combinational sprite ROM at a
//            programmable rate, moves the sprite left/right once per vsync,
//            and looks up colours through a two-stage pixel pipeline with
//            matching sync delay.
// Ports    : clk, rst_n                 pixel clock, async active-low reset
//            pix_x, pix_y, video_active raster position / display enable
//            hsync_in, vsync_in         raw syncs
//            speed, step                frame rate divider, pixels per vsync
//            motion_en, pause, reverse  motion / animation controls
//            lut_frame, lut_x, lut_y    address to the external sprite ROM
//            lut_pixel                  ROM palette index (same cycle)
//            hsync_out, vsync_out       syncs delayed 2 cycles
//            rgb                        registered {R,G,B} 2 bits each
// Macro    : GOOSE_MIRROR_EN - mirror ROM columns while moving left.
// Revision : 1.0 - initial release
// ============================================================================
module goose_sprite_animator
  import goose_pkg::*;
#(
  parameter int         NUM_FRAMES  = 4,
  parameter int         SPRITE_W    = 32,
  parameter int         SPRITE_H    = 32,
  parameter int         SCALE_SHIFT = 3,
  parameter int         IDX_W       = 3,
  parameter int         Y0          = 112,
  parameter int         X0          = 0,
  parameter logic       SYNC_POL    = 1'b0,
  parameter logic [5:0] BG_RGB      = 6'b000001
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    pix_x,
  input  logic [9:0]                    pix_y,
  input  logic                          video_active,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [3:0]                    speed,
  input  logic [1:0]                    step,
  input  logic                          motion_en,
  input  logic                          pause,
  input  logic                          reverse,
  output logic [$clog2(NUM_FRAMES)-1:0] lut_frame,
  output logic [$clog2(SPRITE_W)-1:0]   lut_x,
  output logic [$clog2(SPRITE_H)-1:0]   lut_y,
  input  logic [IDX_W-1:0]              lut_pixel,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic [5:0]                    rgb
);

  localparam int FRAME_W = $clog2(NUM_FRAMES);
  localparam int COL_W   = $clog2(SPRITE_W);
  localparam int ROW_W   = $clog2(SPRITE_H);

  localparam logic [10:0]        c_span_x     = 11'(SPRITE_W << SCALE_SHIFT);
  localparam logic [10:0]        c_span_y     = 11'(SPRITE_H << SCALE_SHIFT);
  localparam logic [10:0]        c_xmax       = 11'(H_ACTIVE - (SPRITE_W << SCALE_SHIFT));
  localparam logic [10:0]        c_x0         = 11'(X0);
  localparam logic [10:0]        c_y0         = 11'(Y0);
  localparam logic [FRAME_W-1:0] c_last_frame = FRAME_W'(NUM_FRAMES - 1);

  // --------------------------------------------------------------------------
  // Sync delay and vsync tick.
  // The two vsync delay flops double as the edge detector: the tick fires in
  // the cycle after vsync_in first reads active, and all frame/position
  // state updates at the end of that cycle.
  // --------------------------------------------------------------------------
  logic r_vs_d, r_vs_dd;
  logic r_hs_d, r_hs_dd;
  logic w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d  <= ~SYNC_POL;
      r_vs_dd <= ~SYNC_POL;
      r_hs_d  <= ~SYNC_POL;
      r_hs_dd <= ~SYNC_POL;
    end else begin
      r_vs_d  <= vsync_in;
      r_vs_dd <= r_vs_d;
      r_hs_d  <= hsync_in;
      r_hs_dd <= r_hs_d;
    end
  end

  assign w_tick    = (r_vs_d == SYNC_POL) && (r_vs_dd != SYNC_POL);
  assign hsync_out = r_hs_dd;
  assign vsync_out = r_vs_dd;

  // --------------------------------------------------------------------------
  // Animation frame counter with vsync divider.
  // --------------------------------------------------------------------------
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] w_frame_next;
  logic [3:0]         r_div;

  always_comb begin
    w_frame_next = r_frame;
    if (reverse) begin
      w_frame_next = (r_frame == '0) ? c_last_frame : r_frame - FRAME_W'(1);
    end else begin
      w_frame_next = (r_frame == c_last_frame) ? '0 : r_frame + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_div   <= 4'd0;
    end else if (w_tick && !pause) begin
      if (r_div == speed) begin
        r_div   <= 4'd0;
        r_frame <= w_frame_next;
      end else if (r_div > speed) begin
        // speed was lowered below the running count: restart the count
        r_div <= 4'd0;
      end else begin
        r_div <= r_div + 4'd1;
      end
    end
  end

  assign lut_frame = r_frame;

  // --------------------------------------------------------------------------
  // Horizontal motion FSM. Positions are 11 bits so sums never wrap.
  // --------------------------------------------------------------------------
  motion_state_t r_state;
  logic [10:0]   r_pos_x;
  logic [10:0]   w_step;
  logic [10:0]   w_pos_sum;

  assign w_step    = {9'd0, step};
  assign w_pos_sum = r_pos_x + w_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD;
      r_pos_x <= c_x0;
    end else if (w_tick) begin
      if (!motion_en) begin
        r_state <= HOLD;
      end else begin
        case (r_state)
          HOLD: begin
            r_state <= MOVE_R;
          end
          MOVE_R: begin
            // step=0 parks the sprite without bouncing
            if (step != 2'd0) begin
              if (w_pos_sum >= c_xmax) begin
                r_pos_x <= c_xmax;
                r_state <= MOVE_L;
              end else begin
                r_pos_x <= w_pos_sum;
              end
            end
          end
          MOVE_L: begin
            if (step != 2'd0) begin
              if (r_pos_x <= w_step) begin
                r_pos_x <= 11'd0;
                r_state <= MOVE_R;
              end else begin
                r_pos_x <= r_pos_x - w_step;
              end
            end
          end
          default: begin
            r_state <= HOLD;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: sprite-relative coordinates and ROM address.
  // pix_x/pix_y < 1024 and pos_x <= 640, so the 11-bit differences are
  // valid two's complement and bit 10 is the sign.
  // --------------------------------------------------------------------------
  logic [10:0]      w_rel_x;
  logic [10:0]      w_rel_y;
  logic             w_in_sprite;
  logic [COL_W-1:0] w_col;

  assign w_rel_x     = {1'b0, pix_x} - r_pos_x;
  assign w_rel_y     = {1'b0, pix_y} - c_y0;
  assign w_in_sprite = !w_rel_x[10] && (w_rel_x < c_span_x) &&
                       !w_rel_y[10] && (w_rel_y < c_span_y);
  assign w_col       = w_rel_x[SCALE_SHIFT +: COL_W];
  assign lut_y       = w_rel_y[SCALE_SHIFT +: ROW_W];

`ifdef GOOSE_MIRROR_EN
  localparam logic [COL_W-1:0] c_last_col = COL_W'(SPRITE_W - 1);
  // Flip columns while travelling left so the goose faces its heading.
  assign lut_x = (r_state == MOVE_L) ? (c_last_col - w_col) : w_col;
`else
  assign lut_x = w_col;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: capture ROM output and per-pixel qualifiers.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s1_in;
  logic             r_s1_va;
  logic [1:0]       r_s1_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_idx <= '0;
      r_s1_in  <= 1'b0;
      r_s1_va  <= 1'b0;
      r_s1_sub <= 2'b00;
    end else begin
      r_s1_idx <= lut_pixel;
      r_s1_in  <= w_in_sprite;
      r_s1_va  <= video_active;
      r_s1_sub <= pix_x[1:0] ^ pix_y[1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: palette and output colour register.
  // --------------------------------------------------------------------------
  logic [5:0] w_pal_rgb;
  logic [5:0] r_rgb;

  goose_palette #(
    .IDX_W (IDX_W)
  ) u_palette (
    .idx      (r_s1_idx),
    .subpixel (r_s1_sub),
    .rgb      (w_pal_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 6'b000000;
    end else if (!r_s1_va) begin
      r_rgb <= 6'b000000;
    end else if (!r_s1_in || (r_s1_idx == '0)) begin
      r_rgb <= BG_RGB;
    end else begin
      r_rgb <= w_pal_rgb;
    end
  end

  assign rgb = r_rgb;

endmodule
`default_nettype wire

// File: doc/goose_sprite_animator.md
Name: goose_sprite_animator

Overview:
- Parametrised successor to the static single-frame goose display.
- Renders an animated, multi-frame sprite at a moving position on the VGA raster:
  - cycles through NUM_FRAMES sprite frames at a programmable rate;
  - bounces the sprite horizontally;
  - pipelines the sprite-ROM and palette lookups, with matching sync delay.
- Sits between hvsync_generator and uo_out. The sprite ROM stays external as a combinational LUT; the palette is internal.

Parameters:
- NUM_FRAMES, 4: animation frames in external ROM (≥2).
- SPRITE_W, 32: sprite width in ROM pixels (power of 2).
- SPRITE_H, 32: sprite height in ROM pixels (power of 2).
- SCALE_SHIFT, 3: upscale factor 2^SCALE_SHIFT screen pixels per ROM pixel.
- IDX_W, 3: palette index width; index 0 is transparent.
- Y0, 112: fixed sprite top row (screen pixels).
- X0, 0: sprite left column after reset.
- SYNC_POL, 0: sync active level (0 = active-low).
- BG_RGB, 6'b000001: background {R,G,B} 2 bits each, used where transparent or outside the sprite.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pix_x  in  10  current column from hvsync_generator
- pix_y  in  10  current row
- video_active  in  1  display_on
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- speed  in  4  animation rate: speed+1 vsyncs per frame step
- step  in  2  horizontal pixels moved per vsync (0 = none)
- motion_en  in  1  enable horizontal motion
- pause  in  1  freeze animation frame
- reverse  in  1  play frames in descending order
- lut_frame  out  $clog2(NUM_FRAMES)  frame select to ROM
- lut_x  out  $clog2(SPRITE_W)  ROM column
- lut_y  out  $clog2(SPRITE_H)  ROM row
- lut_pixel  in  IDX_W  ROM output, combinational in same cycle
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - rgb=0.
  - hsync_out/vsync_out at their inactive level (~SYNC_POL).
  - Frame counter 0, vsync divider 0, pos_x=X0.
  - Motion FSM = HOLD; sync delay pipeline filled with the inactive level.
- Tick: one-cycle internal pulse, the cycle after vsync_in transitions to SYNC_POL (edge detect on a registered copy). All frame and position state changes only on a tick, so no tearing mid-frame.
- Animation:
  - On a tick with pause=0: if div==speed, then div←0 and the frame steps; else div++.
  - Step direction: +1 mod NUM_FRAMES when reverse=0; −1 mod NUM_FRAMES when reverse=1.
  - Wrap: NUM_FRAMES−1→0 forward, 0→NUM_FRAMES−1 reverse.
  - pause=1 holds both the frame and the divider.
  - A speed change takes effect at the next compare. If div>speed, the divider resets to 0 on that tick.
- Motion FSM, states HOLD, MOVE_R, MOVE_L; XMAX = 640 − (SPRITE_W<<SCALE_SHIFT):
  - HOLD → MOVE_R on a tick with motion_en=1. No position change on that tick.
  - MOVE_R: pos_x += step. If the result is ≥ XMAX, pos_x←XMAX and the state goes to MOVE_L.
  - MOVE_L: if pos_x ≤ step, pos_x←0 and the state goes to MOVE_R; else pos_x −= step.
  - motion_en=0 on any tick → HOLD, pos_x retained.
  - Position arithmetic is 11 bits wide, so there is no wrap.
- Pixel pipeline, 2-cycle latency from pix_x/pix_y to rgb:
  - Stage 0, combinational:
    - rel_x = pix_x − pos_x; rel_y = pix_y − Y0.
    - in_sprite = both non-negative and below the scaled W/H.
    - lut_x = rel_x>>SCALE_SHIFT; lut_y = rel_y>>SCALE_SHIFT; lut_frame = frame.
  - Stage 1 registers: lut_pixel, in_sprite, video_active, and subpixel = pix_x[1:0]^pix_y[1:0].
  - Stage 2 registers rgb:
    - video_active=0 → 0;
    - else !in_sprite or index 0 → BG_RGB;
    - else palette(index, subpixel).
  - hsync and vsync each pass through a 2-flop delay so they stay aligned with rgb.
- Boundaries:
  - Sprite at pos_x=XMAX: its last column lands on pixel 639.
  - step=0 in MOVE_R/L: the position stays put and no bounce occurs.
  - Reset mid-line: outputs go to reset values immediately. The first valid rgb is the 3rd clock after release.

Optional Feature:
- GOOSE_MIRROR_EN:
  - Defined: while the FSM is in MOVE_L, lut_x = (SPRITE_W−1) − (rel_x>>SCALE_SHIFT), so the goose faces its direction of travel.
  - Undefined: lut_x is never mirrored; MOVE_L renders identically to MOVE_R.

Decomposition:
- Package goose_pkg: H_ACTIVE=640, V_ACTIVE=480, rgb6_t typedef, motion_state_t enum {HOLD, MOVE_R, MOVE_L}.
- Sub-module goose_palette: combinational, index + subpixel → rgb6_t, with dither table. It is instantiated once, at stage 2.

Test Plan:
- Reset release with all inputs 0 → rgb=0, syncs inactive; after 3 clocks active pixels outside the sprite = BG_RGB (6'b000001).
- speed=2, pause=0, reverse=0, 12 vsyncs → frame sequence 0,0,0,1,1,1,2,2,2,3,3,3, then 0 on tick 13.
- reverse=1 from frame 0, speed=0 → next ticks give 3,2,1,0. pause=1 then holds the frame across 5 ticks.
- motion_en=1, step=3, X0=0, default sizes (XMAX=384):
  - first tick enters MOVE_R with pos 0;
  - after 128 MOVE_R ticks pos=384 and state=MOVE_L;
  - the next tick gives pos=381.
- ROM model returns index 0 at lut_x=0 → that column shows BG_RGB. A nonzero index appears 2 clocks after pix_x with hsync_out aligned. With GOOSE_MIRROR_EN in MOVE_L, pix_x=pos_x drives lut_x=31.
- Async reset asserted mid-frame during MOVE_L at pos 200 → pos_x=X0, state HOLD, frame 0 and rgb=0 within the same cycle.
